// File: rtl/hex_counter_ctrl_if.sv
// Button inputs and counter status outputs of the hex counter controller.
// Latency: none, wiring only.
// Backpressure: none; keys are raw levels and outputs are free-running.
interface hex_counter_ctrl_if;
  logic       key_up;
  logic       key_down;
  logic       key_clr;
  logic       key_mode;
  logic [3:0] x;
  logic [1:0] mode;
  logic       tick;
  logic       wrap;

  // Stimulus side: drives the raw buttons, observes the counter
  modport master (
    output key_up, key_down, key_clr, key_mode,
    input  x, mode, tick, wrap
  );

  // Controller side: samples the buttons, drives the counter
  modport slave (
    input  key_up, key_down, key_clr, key_mode,
    output x, mode, tick, wrap
  );
endinterface

// File: rtl/hex_counter_ctrl.sv
// Debounced-button and auto-stepping 4-bit counter feeding the 2-digit 7-seg decoder.
// Latency: a key held from edge k takes effect on x/mode at edge k+DEBOUNCE_CYCLES+3.
// Backpressure: none; keys are sampled every cycle and the outputs are free-running.
module hex_counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_CYCLES     = 10
) (
  input  logic               clk,
  input  logic               rst,
  hex_counter_ctrl_if.slave  bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = $clog2(TICK_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;

  // Key bit order everywhere: {mode, clr, down, up}
  logic [3:0] w_keys;
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] w_db;
  logic [3:0] r_db_d;
  logic [3:0] r_press;

  logic [3:0]      r_x;
  logic [1:0]      r_mode;
  logic [PS_W-1:0] r_ps;
  logic            r_tick;
  logic            r_wrap;

  logic [3:0]      w_x_nxt;
  logic [1:0]      w_mode_nxt;
  logic [PS_W-1:0] w_ps_nxt;
  logic            w_tick_nxt;
  logic            w_wrap_nxt;
  logic            w_step_up;
  logic            w_step_dn;

  logic w_ev_up;
  logic w_ev_dn;
  logic w_ev_clr;
  logic w_ev_mode;

  assign w_keys = {bus.key_mode, bus.key_clr, bus.key_down, bus.key_up};

  // Two-flop synchronizer, debounced-level history and registered press pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_db_d  <= '0;
      r_press <= '0;
    end else begin
      r_s1    <= w_keys;
      r_s2    <= r_s1;
      r_db_d  <= w_db;
      r_press <= w_db & ~r_db_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_db
    logic [DB_W-1:0] r_cnt;
    logic            r_lvl;

    // Accept a new level only after it has held for DEBOUNCE_CYCLES synchronized cycles
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_s2[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_db[g] = r_lvl;
  end

  assign w_ev_up   = r_press[0];
  assign w_ev_dn   = r_press[1];
  assign w_ev_clr  = r_press[2];
  assign w_ev_mode = r_press[3];

  // Next-state decision: clear beats mode change, which beats any step
  always_comb begin
    w_x_nxt    = r_x;
    w_mode_nxt = r_mode;
    w_ps_nxt   = r_ps;
    w_tick_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    w_step_up  = 1'b0;
    w_step_dn  = 1'b0;

    if (w_ev_clr) begin
      w_x_nxt  = 4'd0;
      w_ps_nxt = '0;
    end else if (w_ev_mode) begin
      w_ps_nxt = '0;
      case (r_mode)
        MODE_MANUAL: w_mode_nxt = MODE_UP;
        MODE_UP:     w_mode_nxt = MODE_DOWN;
        default:     w_mode_nxt = MODE_MANUAL;
      endcase
    end else if (r_mode == MODE_MANUAL) begin
      // Simultaneous up and down cancel out
      w_step_up = w_ev_up & ~w_ev_dn;
      w_step_dn = w_ev_dn & ~w_ev_up;
    end else if (r_ps == PS_LAST) begin
      w_ps_nxt   = '0;
      w_tick_nxt = 1'b1;
      w_step_up  = (r_mode == MODE_UP);
      w_step_dn  = (r_mode == MODE_DOWN);
    end else begin
      w_ps_nxt = r_ps + 1'b1;
    end

    if (w_step_up) begin
      w_x_nxt    = r_x + 4'd1;
      w_wrap_nxt = (r_x == 4'hF);
    end else if (w_step_dn) begin
      w_x_nxt    = r_x - 4'd1;
      w_wrap_nxt = (r_x == 4'h0);
    end
  end

  // Counter, mode, prescaler and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= 4'd0;
      r_mode <= MODE_MANUAL;
      r_ps   <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_mode <= w_mode_nxt;
      r_ps   <= w_ps_nxt;
      r_tick <= w_tick_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign bus.x    = r_x;
  assign bus.mode = r_mode;
  assign bus.tick = r_tick;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_hex_counter_ctrl.sv
// Bench for hex_counter_ctrl: table of button presses plus hand-built auto/reset sequences.
// Expected outputs are queued with the edge number they are due at and checked on negedge.
// Default parameters: 4-cycle debounce, 10-cycle tick.
module tb_hex_counter_ctrl;

    localparam logic [3:0] K_UP   = 4'b0001;
    localparam logic [3:0] K_DN   = 4'b0010;
    localparam logic [3:0] K_CLR  = 4'b0100;
    localparam logic [3:0] K_MODE = 4'b1000;

    typedef struct {
        int         due;
        logic [7:0] exp;
        string      name;
    } chk_t;

    typedef struct {
        logic [3:0] keys;
        int         hold;
        logic [3:0] exp_x;
        logic       exp_wrap;
    } vec_t;

    logic clk;
    logic rst;
    int   edge_n;
    int   n_cmp;
    int   n_bad;
    logic [7:0] got;
    chk_t sb[$];

    hex_counter_ctrl_if u_if ();

    hex_counter_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Compare every queued expectation that falls due at this edge
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= edge_n) begin
                n_cmp++;
                got = {u_if.x, u_if.mode, u_if.tick, u_if.wrap};
                if (sb[i].due < edge_n || got !== sb[i].exp) begin
                    n_bad++;
                    $display("FAIL %s @edge %0d: got x=%0d mode=%0d tick=%0d wrap=%0d, expected x=%0d mode=%0d tick=%0d wrap=%0d",
                             sb[i].name, edge_n, got[7:4], got[3:2], got[1], got[0],
                             sb[i].exp[7:4], sb[i].exp[3:2], sb[i].exp[1], sb[i].exp[0]);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic expect_at(input int due, input logic [3:0] x, input logic [1:0] m,
                             input logic t, input logic w, input string nm);
        chk_t c;
        c.due  = due;
        c.exp  = {x, m, t, w};
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic set_keys(input logic [3:0] k);
        u_if.key_up   = k[0];
        u_if.key_down = k[1];
        u_if.key_clr  = k[2];
        u_if.key_mode = k[3];
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_edge(input int t);
        while (edge_n < t) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        set_keys(k);
        idle(hold);
        set_keys(4'h0);
    endtask

    vec_t vt[11];
    logic [3:0] cur_x;
    int e0, m, c, m2, m3, r0, guard;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vt[0]  = '{K_UP,        10, 4'd2,  1'b0};
        vt[1]  = '{K_UP,        10, 4'd3,  1'b0};
        vt[2]  = '{K_UP,         3, 4'd3,  1'b0};  // 3-cycle glitch
        vt[3]  = '{K_CLR,       10, 4'd0,  1'b0};
        vt[4]  = '{K_DN,        10, 4'd15, 1'b1};
        vt[5]  = '{K_UP | K_DN, 10, 4'd15, 1'b0};
        vt[6]  = '{K_UP,        10, 4'd0,  1'b1};
        vt[7]  = '{K_DN,        10, 4'd15, 1'b1};
        vt[8]  = '{K_CLR,       10, 4'd0,  1'b0};  // clear from 15 gives no wrap
        vt[9]  = '{K_DN,        10, 4'd15, 1'b1};
        vt[10] = '{K_DN,        10, 4'd14, 1'b0};

        // Reset with every key held
        rst = 1'b1;
        set_keys(4'hF);
        expect_at(1, 4'd0, 2'b00, 1'b0, 1'b0, "reset_e1");
        expect_at(2, 4'd0, 2'b00, 1'b0, 1'b0, "reset_e2");
        idle(2);

        n_cmp++;
        if (u_if.x !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_x: got x=%0d", u_if.x);
        end
        n_cmp++;
        if (u_if.mode !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_mode: got mode=%0d", u_if.mode);
        end
        n_cmp++;
        if (u_if.tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_tick: got tick=%0d", u_if.tick);
        end
        n_cmp++;
        if (u_if.wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_wrap: got wrap=%0d", u_if.wrap);
        end

        // First edge after release samples up; effect exactly 7 edges later
        rst = 1'b0;
        set_keys(K_UP);
        expect_at(edge_n + 7, 4'd0, 2'b00, 1'b0, 1'b0, "post_rst_latency");
        expect_at(edge_n + 8, 4'd1, 2'b00, 1'b0, 1'b0, "post_rst_up");
        expect_at(edge_n + 9, 4'd1, 2'b00, 1'b0, 1'b0, "post_rst_hold");
        idle(10);
        set_keys(4'h0);
        idle(10);
        cur_x = 4'd1;

        // Manual-mode table
        for (int i = 0; i < 11; i++) begin
            expect_at(edge_n + 7, cur_x, 2'b00, 1'b0, 1'b0, $sformatf("vec%0d_before", i));
            expect_at(edge_n + 8, vt[i].exp_x, 2'b00, 1'b0, vt[i].exp_wrap, $sformatf("vec%0d_effect", i));
            expect_at(edge_n + 9, vt[i].exp_x, 2'b00, 1'b0, 1'b0, $sformatf("vec%0d_after", i));
            press(vt[i].keys, vt[i].hold);
            idle(20 - vt[i].hold);
            cur_x = vt[i].exp_x;
        end

        // AUTO_UP from 14, up/down ignored, wrap on 15->0
        e0 = edge_n;
        m  = e0 + 8;
        expect_at(m - 1,  4'd14, 2'b00, 1'b0, 1'b0, "mode1_before");
        expect_at(m,      4'd14, 2'b01, 1'b0, 1'b0, "mode1_enter");
        expect_at(m + 9,  4'd14, 2'b01, 1'b0, 1'b0, "aup_pre_tick");
        expect_at(m + 10, 4'd15, 2'b01, 1'b1, 1'b0, "aup_tick15");
        expect_at(m + 11, 4'd15, 2'b01, 1'b0, 1'b0, "aup_tick_width");
        expect_at(m + 13, 4'd15, 2'b01, 1'b0, 1'b0, "aup_up_ignored");
        expect_at(m + 20, 4'd0,  2'b01, 1'b1, 1'b1, "aup_wrap");
        expect_at(m + 21, 4'd0,  2'b01, 1'b0, 1'b0, "aup_wrap_width");
        expect_at(m + 25, 4'd0,  2'b01, 1'b0, 1'b0, "aup_down_ignored");
        expect_at(m + 30, 4'd1,  2'b01, 1'b1, 1'b0, "aup_tick1");
        expect_at(m + 110, 4'd9, 2'b01, 1'b1, 1'b0, "aup_tick9");
        press(K_MODE, 10);
        idle(2);
        press(K_UP, 10);
        idle(2);
        press(K_DN, 10);

        // Clear at x=9 mid-prescale: x=0, no wrap, mode kept, next step 10 later
        c = m + 115;
        to_edge(c - 8);
        expect_at(c - 1,  4'd9, 2'b01, 1'b0, 1'b0, "clr_before");
        expect_at(c,      4'd0, 2'b01, 1'b0, 1'b0, "clr_effect");
        expect_at(c + 9,  4'd0, 2'b01, 1'b0, 1'b0, "clr_pre_tick");
        expect_at(c + 10, 4'd1, 2'b01, 1'b1, 1'b0, "clr_next_tick");
        press(K_CLR, 10);

        // Mode event lands on a tick cycle: step suppressed, then AUTO_DOWN
        to_edge(c + 12);
        m2 = c + 20;
        expect_at(m2 - 1,  4'd1,  2'b01, 1'b0, 1'b0, "mode2_before");
        expect_at(m2,      4'd1,  2'b10, 1'b0, 1'b0, "mode2_enter");
        expect_at(m2 + 10, 4'd0,  2'b10, 1'b1, 1'b0, "adn_tick0");
        expect_at(m2 + 20, 4'd15, 2'b10, 1'b1, 1'b1, "adn_wrap");
        expect_at(m2 + 21, 4'd15, 2'b10, 1'b0, 1'b0, "adn_wrap_width");
        press(K_MODE, 10);

        // Back to MANUAL: ticks stop
        to_edge(m2 + 22);
        m3 = m2 + 30;
        expect_at(m3 - 1,  4'd15, 2'b10, 1'b0, 1'b0, "mode0_before");
        expect_at(m3,      4'd15, 2'b00, 1'b0, 1'b0, "mode0_enter");
        expect_at(m3 + 10, 4'd15, 2'b00, 1'b0, 1'b0, "manual_no_tick_a");
        expect_at(m3 + 20, 4'd15, 2'b00, 1'b0, 1'b0, "manual_no_tick_b");
        press(K_MODE, 10);

        // Reset mid-prescale and 2 cycles into a mode press
        to_edge(m3 + 21);
        r0 = edge_n;
        expect_at(r0 + 8,  4'd15, 2'b01, 1'b0, 1'b0, "rst_seq_auto");
        expect_at(r0 + 15, 4'd15, 2'b01, 1'b0, 1'b0, "rst_seq_pre");
        expect_at(r0 + 16, 4'd0,  2'b00, 1'b0, 1'b0, "rst_mid_effect");
        expect_at(r0 + 26, 4'd0,  2'b00, 1'b0, 1'b0, "rst_no_late_a");
        expect_at(r0 + 36, 4'd0,  2'b00, 1'b0, 1'b0, "rst_no_late_b");
        expect_at(r0 + 40, 4'd0,  2'b00, 1'b0, 1'b0, "rst_no_late_c");
        press(K_MODE, 10);
        to_edge(r0 + 13);
        set_keys(K_MODE);
        to_edge(r0 + 15);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        set_keys(4'h0);
        to_edge(r0 + 41);

        n_cmp++;
        if (u_if.x !== 4'd0) begin
            n_bad++;
            $display("FAIL end_x: got x=%0d", u_if.x);
        end
        n_cmp++;
        if (u_if.mode !== 2'b00) begin
            n_bad++;
            $display("FAIL end_mode: got mode=%0d", u_if.mode);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, due edge %0d, now edge %0d", sb[0].name, sb[0].due, edge_n);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
